// File: rtl/gate_sweep_if.sv
// gate_sweep_if: control and observation bundle between a sweep master and gate_sweep_ctrl
interface gate_sweep_if #(parameter int HOLD_W = 8);
  logic start, abort, gate_x, a, b, busy, done, pass;
  logic [HOLD_W-1:0] hold_cycles;
  logic [1:0] vec_idx;
  logic [2:0] err_count;
  modport master(output start, abort, hold_cycles, gate_x, input a, b, vec_idx, busy, done, pass, err_count);
  modport slave(input start, abort, hold_cycles, gate_x, output a, b, vec_idx, busy, done, pass, err_count);
endinterface

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: drives all four input vectors into an AND gate, holding each H cycles, and counts mismatches
module gate_sweep_ctrl #(parameter int HOLD_W = 8) (
  input logic clk,
  input logic rst,
  gate_sweep_if.slave s
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [HOLD_W-1:0] h, h_n, cnt, cnt_n, hs;
  logic [1:0] idx, idx_n;
  logic [2:0] err, err_n;
  logic busy, busy_n, done, done_n, pass, pass_n, miss;
  assign hs = s.hold_cycles == '0 ? HOLD_W'(1) : s.hold_cycles;
  assign miss = s.gate_x != (idx[1] & idx[0]);
  assign s.a = idx[1];
  assign s.b = idx[0];
  assign s.vec_idx = idx;
  assign s.busy = busy;
  assign s.done = done;
  assign s.pass = pass;
  assign s.err_count = err;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      h <= '0;
      cnt <= '0;
      idx <= '0;
      err <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      state <= state_n;
      h <= h_n;
      cnt <= cnt_n;
      idx <= idx_n;
      err <= err_n;
      busy <= busy_n;
      done <= done_n;
      pass <= pass_n;
    end
  end
  always_comb begin
    state_n = state;
    h_n = h;
    cnt_n = cnt;
    idx_n = idx;
    err_n = err;
    busy_n = busy;
    done_n = 1'b0;
    pass_n = pass;
    case (state)
      IDLE: if (s.start) begin
        state_n = WAIT;
        h_n = hs;
        cnt_n = hs - HOLD_W'(1);
        idx_n = '0;
        err_n = '0;
        busy_n = 1'b1;
        pass_n = 1'b0;
      end
      WAIT: if (s.abort) begin
        state_n = IDLE;
        cnt_n = '0;
        idx_n = '0;
        err_n = '0;
        busy_n = 1'b0;
        pass_n = 1'b0;
      end else if (cnt != '0) begin
        cnt_n = cnt - HOLD_W'(1);
      end else begin
        // the final vector's compare lands in err_n before pass is derived from it
        err_n = err + {2'b00, miss};
        idx_n = idx + 2'd1;
        cnt_n = idx == 2'd3 ? '0 : h - HOLD_W'(1);
        state_n = idx == 2'd3 ? DONE : WAIT;
        busy_n = idx != 2'd3;
        done_n = idx == 2'd3;
        pass_n = idx == 2'd3 ? err_n == '0 : 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: scoreboard bench for gate_sweep_ctrl sweeps, aborts and resets
module tb_gate_sweep_ctrl;
  logic clk = 0, rst = 1;
  int errors = 0, checks = 0, mode = 0;
  typedef struct packed {logic [2:0] err; logic pass;} res_t;
  res_t sb[$];
  gate_sweep_if #(.HOLD_W(8)) bus();
  gate_sweep_ctrl #(.HOLD_W(8)) dut(.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;
  assign bus.gate_x = mode == 0 ? (bus.a & bus.b) : (mode == 1);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input int hold, input int m, input bit noise, input bit with_abort);
    int h, w;
    res_t e, got;
    h = hold == 0 ? 1 : hold;
    mode = m;
    e.err = m == 0 ? 3'd0 : m == 1 ? 3'd3 : 3'd1;
    e.pass = e.err == 3'd0;
    sb.push_back(e);
    bus.hold_cycles = 8'(hold);
    bus.start = 1;
    bus.abort = with_abort;
    step();
    bus.start = 0;
    bus.abort = 0;
    for (int k = 0; k < 4 * h; k++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.vec_idx !== 2'(k / h) || {bus.a, bus.b} !== 2'(k / h) || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL sweep_cycle h=%0d k=%0d: got busy=%b idx=%0d ab=%b%b done=%b, want busy=1 idx=%0d ab=%0d done=0",
                 h, k, bus.busy, bus.vec_idx, bus.a, bus.b, bus.done, k / h, k / h);
      end
      if (noise) begin
        bus.start = k[0];
        bus.hold_cycles = 8'($urandom_range(0, 255));
      end
      step();
    end
    bus.start = 0;
    w = 0;
    while (bus.done !== 1'b1 && w < 8) begin
      step();
      w++;
    end
    checks++;
    if (w != 0 || bus.done !== 1'b1 || bus.busy !== 1'b0 || {bus.a, bus.b} !== 2'b00) begin
      errors++;
      $display("FAIL done_timing h=%0d: got late_by=%0d done=%b busy=%b ab=%b%b, want late_by=0 done=1 busy=0 ab=00",
               h, w, bus.done, bus.busy, bus.a, bus.b);
    end
    if (bus.done === 1'b1) begin
      got = {bus.err_count, bus.pass};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL result mode=%0d: got err=%0d pass=%b, want err=%0d pass=%b", m, got.err, got.pass, e.err, e.pass);
      end
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || {bus.err_count, bus.pass} !== e) begin
        errors++;
        $display("FAIL idle_hold mode=%0d: got done=%b busy=%b err=%0d pass=%b, want done=0 busy=0 err=%0d pass=%b",
                 m, bus.done, bus.busy, bus.err_count, bus.pass, e.err, e.pass);
      end
    end else begin
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset();
    rst = 1;
    bus.start = 0;
    bus.abort = 0;
    bus.hold_cycles = 0;
    step();
    step();
    checks++;
    if ({bus.a, bus.b, bus.vec_idx, bus.busy, bus.done, bus.pass, bus.err_count} !== 10'b0) begin
      errors++;
      $display("FAIL reset: got ab=%b%b idx=%0d busy=%b done=%b pass=%b err=%0d, want all 0",
               bus.a, bus.b, bus.vec_idx, bus.busy, bus.done, bus.pass, bus.err_count);
    end
    rst = 0;
    step();
  endtask

  task automatic test_basic();
    sweep(3, 0, 0, 0);
  endtask

  task automatic test_zero_hold();
    sweep(0, 0, 0, 1);
  endtask

  task automatic test_mismatch();
    sweep(2, 1, 0, 0);
    sweep(2, 2, 0, 0);
  endtask

  task automatic test_ignore_start();
    sweep(2, 0, 1, 0);
  endtask

  task automatic test_abort();
    mode = 1;
    bus.hold_cycles = 2;
    bus.start = 1;
    step();
    bus.start = 0;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (bus.vec_idx !== 2'd2 || bus.err_count !== 3'd2) begin
      errors++;
      $display("FAIL pre_abort: got idx=%0d err=%0d, want idx=2 err=2", bus.vec_idx, bus.err_count);
    end
    bus.abort = 1;
    step();
    bus.abort = 0;
    checks++;
    if ({bus.a, bus.b, bus.vec_idx, bus.busy, bus.done, bus.pass, bus.err_count} !== 10'b0) begin
      errors++;
      $display("FAIL abort: got ab=%b%b idx=%0d busy=%b done=%b pass=%b err=%0d, want all 0",
               bus.a, bus.b, bus.vec_idx, bus.busy, bus.done, bus.pass, bus.err_count);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL post_abort k=%0d: got done=%b busy=%b, want done=0 busy=0", k, bus.done, bus.busy);
      end
    end
    sweep(2, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    mode = 0;
    bus.hold_cycles = 3;
    bus.start = 1;
    step();
    bus.start = 0;
    for (int k = 0; k < 5; k++) step();
    rst = 1;
    bus.abort = 1;
    bus.start = 1;
    step();
    checks++;
    if ({bus.a, bus.b, bus.vec_idx, bus.busy, bus.done, bus.pass, bus.err_count} !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid: got ab=%b%b idx=%0d busy=%b done=%b pass=%b err=%0d, want all 0",
               bus.a, bus.b, bus.vec_idx, bus.busy, bus.done, bus.pass, bus.err_count);
    end
    rst = 0;
    bus.abort = 0;
    bus.start = 0;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, want busy=0 done=0", bus.busy, bus.done);
    end
    sweep(1, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    sweep(1, 2, 0, 0);
    sweep(4, 1, 0, 0);
    sweep(1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_hold();
    test_mismatch();
    test_ignore_start();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 SHALL have parameter HOLD_W, default 8, width of the per-vector hold count.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request one full sweep; accepted only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous cancel of a sweep in progress.
REQ-006 SHALL have port hold_cycles  input  HOLD_W  cycles each vector is held; sampled when start is accepted.
REQ-007 SHALL have port gate_x  input  1  output of the 2-input AND gate under control.
REQ-008 SHALL have port a  output  1  registered drive to the gate's a input.
REQ-009 SHALL have port b  output  1  registered drive to the gate's b input.
REQ-010 SHALL have port vec_idx  output  2  index of the vector currently driven; a=vec_idx[1], b=vec_idx[0].
REQ-011 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-013 SHALL have port pass  output  1  high when the last completed sweep had zero mismatches.
REQ-014 SHALL have port err_count  output  3  number of mismatching vectors in the current or last sweep, range 0..4.

Function
REQ-015 SHALL implement the states IDLE, WAIT and DONE.
REQ-016 SHALL define H = hold_cycles latched at start; a latched value of 0 SHALL be treated as H=1.
REQ-017 In IDLE with start=1 at an edge: next state WAIT, vec_idx=0, a=b=0, busy=1, err_count=0, pass=0, hold counter=H-1.
REQ-018 In WAIT: counter!=0 -> counter decrements; a, b and vec_idx unchanged.
REQ-019 In WAIT with counter==0, gate_x SHALL be compared against vec_idx[1]&vec_idx[1-1]; on mismatch err_count increments by 1.
REQ-020 In the same cycle as REQ-019, if vec_idx!=3: vec_idx increments, a/b follow the new index, counter reloads to H-1.
REQ-021 In the same cycle as REQ-019, if vec_idx==3: next state DONE; a=b=0, vec_idx=0.
REQ-022 Each vector SHALL be driven for exactly H cycles; vector order 00,01,10,11; busy high for exactly 4H cycles.
REQ-023 In DONE: done=1 for exactly one cycle, busy=0, pass=(err_count==0) including the final compare; next state IDLE.
REQ-024 pass and err_count SHALL hold their values in IDLE until the next accepted start.
REQ-025 start while in WAIT or DONE SHALL be ignored; no queuing.
REQ-026 Changes to hold_cycles after start is accepted SHALL have no effect on the running sweep.
REQ-027 abort=1 in WAIT: next state IDLE, a=b=0, vec_idx=0, busy=0, err_count=0, pass=0, no done pulse.
REQ-028 abort in IDLE or DONE SHALL be ignored; if start and abort are both high in IDLE, start wins.
REQ-029 Mismatch detection on vector 11 in the final WAIT cycle SHALL be counted before pass is computed.

Reset
REQ-030 rst=1 at an edge SHALL force state IDLE, a=0, b=0, vec_idx=0, busy=0, done=0, pass=0, err_count=0, counter=0.
REQ-031 rst SHALL take priority over start and abort, in every state, including mid-sweep.

Verification
REQ-032 rst, then start with hold_cycles=3 and gate_x from a correct AND gate -> a/b = 00,01,10,11 for 3 cycles each, busy 12 cycles, done pulse, pass=1, err_count=0.
REQ-033 start with hold_cycles=0 -> each vector held 1 cycle, busy 4 cycles, done on the 5th cycle after start.
REQ-034 gate_x tied 1, hold_cycles=2 -> err_count=3, pass=0 at done; gate_x tied 0 -> err_count=1, pass=0.
REQ-035 start pulses and hold_cycles changes during busy -> sweep timing unchanged, single done pulse.
REQ-036 abort while vec_idx=2 -> next cycle a=b=0, busy=0, err_count=0, no done; a following start runs a full clean sweep.
REQ-037 rst asserted mid-sweep with abort and start also high -> all outputs at reset values next cycle, state IDLE.
